// File: rtl/hd6309_clkgen.sv
// E/Q quadrature clock generator for the hd6309e core, with MRDY stretching of
// E-high and a post-reset hold of the core's nRESET for a fixed number of E cycles.
`timescale 1ns/1ps
module hd6309_clkgen #(
  parameter int unsigned CLK_DIV     = 1,
  parameter int unsigned RST_ECYCLES = 16,
  parameter int unsigned MAX_STRETCH = 4
) (
  input  logic CLK,
  input  logic nRESET,
  input  logic MRDY,
  output logic E,
  output logic Q,
  output logic nCPURESET,
  output logic E_RISE,
  output logic E_FALL,
  output logic STRETCH
);

  // Phase encoding chosen so E = phase[1] and Q = phase[1]^phase[0];
  // the (E,Q) sequence 00,01,11,10 is Gray, so only one of them moves per step.
  localparam logic [1:0] PH0 = 2'd0;
  localparam logic [1:0] PH1 = 2'd1;
  localparam logic [1:0] PH2 = 2'd2;
  localparam logic [1:0] PH3 = 2'd3;

  localparam logic [7:0] QLAST = 8'(CLK_DIV - 1);
  localparam logic [3:0] SMAX  = 4'(MAX_STRETCH);
  localparam logic [7:0] RLAST = 8'(RST_ECYCLES - 1);

  logic [1:0] sync_q;
  logic [1:0] phase_q, phase_d;
  logic [7:0] qcnt_q, qcnt_d;
  logic [3:0] scnt_q, scnt_d;
  logic [7:0] rcnt_q, rcnt_d;
  logic       e_q, e_d;
  logic       q_q, q_d;
  logic       ncpu_q, ncpu_d;
  logic       rise_q, rise_d;
  logic       fall_q, fall_d;
  logic       str_q, str_d;

  logic run;
  logic qlast;
  logic stretch_ok;

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign run        = sync_q[1];
  assign qlast      = (qcnt_q == QLAST);
  // The core is never stretched while it is still being held in reset.
  assign stretch_ok = ncpu_q && !MRDY && (scnt_q < SMAX);

  always_comb begin
    phase_d = phase_q;
    qcnt_d  = qcnt_q;
    scnt_d  = scnt_q;
    rcnt_d  = rcnt_q;
    ncpu_d  = ncpu_q;
    str_d   = str_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (run) begin
      if (!qlast) begin
        qcnt_d = qcnt_q + 8'd1;
      end else begin
        qcnt_d = 8'd0;
        case (phase_q)
          PH0: phase_d = PH1;
          PH1: begin
            phase_d = PH2;
            rise_d  = 1'b1;
          end
          PH2: phase_d = PH3;
          default: begin
            if (stretch_ok) begin
              scnt_d = scnt_q + 4'd1;
              str_d  = 1'b1;
            end else begin
              phase_d = PH0;
              scnt_d  = 4'd0;
              str_d   = 1'b0;
              fall_d  = 1'b1;
              if (!ncpu_q) begin
                rcnt_d = rcnt_q + 8'd1;
                if (rcnt_q == RLAST) begin
                  ncpu_d = 1'b1;
                end
              end
            end
          end
        endcase
      end
    end
    e_d = phase_d[1];
    q_d = phase_d[1] ^ phase_d[0];
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      phase_q <= PH0;
      qcnt_q  <= 8'd0;
      scnt_q  <= 4'd0;
      rcnt_q  <= 8'd0;
      e_q     <= 1'b0;
      q_q     <= 1'b0;
      ncpu_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      str_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      qcnt_q  <= qcnt_d;
      scnt_q  <= scnt_d;
      rcnt_q  <= rcnt_d;
      e_q     <= e_d;
      q_q     <= q_d;
      ncpu_q  <= ncpu_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      str_q   <= str_d;
    end
  end

  assign E         = e_q;
  assign Q         = q_q;
  assign nCPURESET = ncpu_q;
  assign E_RISE    = rise_q;
  assign E_FALL    = fall_q;
  assign STRETCH   = str_q;

endmodule

// File: tb/tb_hd6309_clkgen.sv
// Event scoreboard bench: expected clock events (edge number, kind, E/Q) are queued
// by the stimulus; a negedge monitor detects events on two DUT configurations and pops.
`timescale 1ns/1ps
module tb_hd6309_clkgen;

  localparam int K_QR   = 0;
  localparam int K_RISE = 1;
  localparam int K_QF   = 2;
  localparam int K_STR  = 3;
  localparam int K_FALL = 4;
  localparam int K_STRF = 5;
  localparam int K_NCPU = 6;

  typedef struct {
    int   kind;
    int   k;
    logic e;
    logic q;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic nRESET;
  logic mrdy_a, mrdy_b;
  logic e_a, q_a, ncr_a, er_a, ef_a, st_a;
  logic e_b, q_b, ncr_b, er_b, ef_b, st_b;

  // A: CLK_DIV=1, RST_ECYCLES=4, MAX_STRETCH=2   B: CLK_DIV=3, RST_ECYCLES=2, MAX_STRETCH=4
  hd6309_clkgen #(.CLK_DIV(1), .RST_ECYCLES(4), .MAX_STRETCH(2)) dut_a (
    .CLK(clk), .nRESET(nRESET), .MRDY(mrdy_a),
    .E(e_a), .Q(q_a), .nCPURESET(ncr_a), .E_RISE(er_a), .E_FALL(ef_a), .STRETCH(st_a)
  );
  hd6309_clkgen #(.CLK_DIV(3), .RST_ECYCLES(2), .MAX_STRETCH(4)) dut_b (
    .CLK(clk), .nRESET(nRESET), .MRDY(mrdy_b),
    .E(e_b), .Q(q_b), .nCPURESET(ncr_b), .E_RISE(er_b), .E_FALL(ef_b), .STRETCH(st_b)
  );

  ev_t exp_a[$];
  ev_t exp_b[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  cyc = 0;
  int  rel_cyc = 0;
  int  lim_a = 0;
  int  lim_b = 0;
  bit  mon_en = 0;
  logic qp_a = 1'b0, sp_a = 1'b0, np_a = 1'b0;
  logic qp_b = 1'b0, sp_b = 1'b0, np_b = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (cyc > 3000) begin
      $display("FAIL watchdog: cycle %0d reached, required finish before 3000", cyc);
      $fatal(1, "watchdog");
    end
  end

  function automatic string kname(input int kind);
    case (kind)
      K_QR:    return "Q_RISE";
      K_RISE:  return "E_RISE";
      K_QF:    return "Q_FALL";
      K_STR:   return "STRETCH_ON";
      K_FALL:  return "E_FALL";
      K_STRF:  return "STRETCH_OFF";
      default: return "NCPU_RISE";
    endcase
  endfunction

  task automatic push_ev(input int id, input int kind, input int k);
    ev_t x;
    x.kind = kind;
    x.k    = k;
    x.e    = (kind == K_RISE || kind == K_QF || kind == K_STR) ? 1'b1 : 1'b0;
    x.q    = (kind == K_QR || kind == K_RISE) ? 1'b1 : 1'b0;
    if (id == 0) exp_a.push_back(x);
    else         exp_b.push_back(x);
  endtask

  // One E cycle starting (P0 entry) at edge s, quarter length d, n stretched quarters.
  task automatic push_cycle(input int id, input int s, input int d, input int n, input bit ncpu);
    int f;
    f = s + (4 + n) * d;
    push_ev(id, K_QR, s + d);
    push_ev(id, K_RISE, s + 2 * d);
    push_ev(id, K_QF, s + 3 * d);
    if (n > 0) push_ev(id, K_STR, s + 4 * d);
    push_ev(id, K_FALL, f);
    if (n > 0) push_ev(id, K_STRF, f);
    if (ncpu) push_ev(id, K_NCPU, f);
  endtask

  task automatic check_ev(input int id, input int kind, input int k, input logic e, input logic q);
    ev_t x;
    bit  have;
    have = 0;
    n_cmp++;
    if (id == 0) begin
      if (exp_a.size() > 0) begin x = exp_a.pop_front(); have = 1; end
    end else begin
      if (exp_b.size() > 0) begin x = exp_b.pop_front(); have = 1; end
    end
    if (!have) begin
      n_bad++;
      $display("FAIL dut%0d event: got %s at edge %0d (E=%b Q=%b), required none", id, kname(kind), k, e, q);
    end else if (x.kind != kind || x.k != k || x.e !== e || x.q !== q) begin
      n_bad++;
      $display("FAIL dut%0d event: got %s at edge %0d (E=%b Q=%b), required %s at edge %0d (E=%b Q=%b)",
               id, kname(kind), k, e, q, kname(x.kind), x.k, x.e, x.q);
    end else begin
      $display("dut%0d %s at edge %0d E=%b Q=%b ok", id, kname(kind), k, e, q);
    end
  endtask

  task automatic observe(input int id, input int k, input logic e, input logic q, input logic er,
                         input logic ef, input logic st, input logic ncr,
                         input logic qp, input logic sp, input logic np);
    if (q && !qp)  check_ev(id, K_QR, k, e, q);
    if (er)        check_ev(id, K_RISE, k, e, q);
    if (!q && qp)  check_ev(id, K_QF, k, e, q);
    if (st && !sp) check_ev(id, K_STR, k, e, q);
    if (ef)        check_ev(id, K_FALL, k, e, q);
    if (!st && sp) check_ev(id, K_STRF, k, e, q);
    if (ncr && !np) check_ev(id, K_NCPU, k, e, q);
  endtask

  always @(negedge clk) begin
    int k;
    k = cyc - rel_cyc;
    if (mon_en && k <= lim_a) observe(0, k, e_a, q_a, er_a, ef_a, st_a, ncr_a, qp_a, sp_a, np_a);
    if (mon_en && k <= lim_b) observe(1, k, e_b, q_b, er_b, ef_b, st_b, ncr_b, qp_b, sp_b, np_b);
    qp_a <= q_a; sp_a <= st_a; np_a <= ncr_a;
    qp_b <= q_b; sp_b <= st_b; np_b <= ncr_b;
  end

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end else begin
      $display("check %s = %0d ok", name, act);
    end
  endtask

  task automatic chk_all_low(input string tag);
    chk({tag, " A.E"}, int'(e_a), 0);
    chk({tag, " A.Q"}, int'(q_a), 0);
    chk({tag, " A.nCPURESET"}, int'(ncr_a), 0);
    chk({tag, " A.E_RISE"}, int'(er_a), 0);
    chk({tag, " A.E_FALL"}, int'(ef_a), 0);
    chk({tag, " A.STRETCH"}, int'(st_a), 0);
    chk({tag, " B.E"}, int'(e_b), 0);
    chk({tag, " B.Q"}, int'(q_b), 0);
    chk({tag, " B.nCPURESET"}, int'(ncr_b), 0);
    chk({tag, " B.STRETCH"}, int'(st_b), 0);
  endtask

  task automatic wait_k(input int n);
    while (cyc - rel_cyc < n) @(negedge clk);
  endtask

  initial begin
    nRESET = 1'b0;
    mrdy_a = 1'b0;
    mrdy_b = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_low("reset");
    chk("reset B.E_RISE", int'(er_b), 0);
    chk("reset B.E_FALL", int'(ef_b), 0);

    // A, MRDY held 0: four reset cycles unstretched, then two stretches each.
    push_cycle(0, 2, 1, 0, 0);
    push_cycle(0, 6, 1, 0, 0);
    push_cycle(0, 10, 1, 0, 0);
    push_cycle(0, 14, 1, 0, 1);
    push_cycle(0, 18, 1, 2, 0);
    push_cycle(0, 24, 1, 2, 0);
    // B: two reset cycles, one stretched quarter, then an unstretched cycle.
    push_cycle(1, 2, 3, 0, 0);
    push_cycle(1, 14, 3, 0, 1);
    push_cycle(1, 26, 3, 1, 0);
    push_cycle(1, 41, 3, 0, 0);

    @(negedge clk);
    lim_a   = 30;
    lim_b   = 53;
    rel_cyc = cyc;
    nRESET  = 1'b1;
    mon_en  = 1;
    wait_k(27); mrdy_b = 1'b1;
    wait_k(33); mrdy_b = 1'b0;
    wait_k(38); mrdy_b = 1'b1;
    wait_k(58);
    chk("phase1 A queue left", exp_a.size(), 0);
    chk("phase1 B queue left", exp_b.size(), 0);
    chk("A.STRETCH before reset pulse", int'(st_a), 1);
    chk("A.E before reset pulse", int'(e_a), 1);
    chk("A.nCPURESET before reset pulse", int'(ncr_a), 1);

    mon_en = 0;
    #2 nRESET = 1'b0;
    #1 chk_all_low("async reset");
    repeat (3) @(negedge clk);
    chk("held reset A.E", int'(e_a), 0);
    chk("held reset A.nCPURESET", int'(ncr_a), 0);

    push_cycle(0, 2, 1, 0, 0);
    push_cycle(0, 6, 1, 0, 0);
    push_cycle(0, 10, 1, 0, 0);
    push_cycle(0, 14, 1, 0, 1);
    push_cycle(0, 18, 1, 2, 0);
    push_cycle(1, 2, 3, 0, 0);
    push_cycle(1, 14, 3, 0, 1);
    lim_a   = 24;
    lim_b   = 26;
    rel_cyc = cyc;
    nRESET  = 1'b1;
    mon_en  = 1;
    wait_k(30);
    chk("phase2 A queue left", exp_a.size(), 0);
    chk("phase2 B queue left", exp_b.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
